wb_resp_mem: RTL and testbench

//  Wishbone B3 responder (slave) with internal word-addressed RAM and programmable wait states.

---
 rtl/wb_resp_mem.sv | 161 ++++++++++++++++
 tb/tb_wb_resp_mem.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_resp_mem.sv
// Wishbone B3 responder with word-addressed internal RAM and programmable wait states.
// Define WB_RESP_BURST_EN to enable linear incrementing bursts (cti=010 / 111).
module wb_resp_mem #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int WAIT_ST = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [31:0]     wb_addr_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o
);
  localparam int         SW       = DW / 8;
  localparam logic [3:0] CNT_INIT = (WAIT_ST == 0) ? 4'd0 : 4'(WAIT_ST - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic          we_q, err_q, bst;
  logic [SW-1:0] sel_q;
  logic [DW-1:0] dat_q;
  logic [DW-1:0] mem [2**AW];

  logic          req, bus_err;
  logic [AW-1:0] bus_idx;
  logic          unused_bits;

  assign req     = wb_cyc_i & wb_stb_i;
  assign bus_idx = wb_addr_i[AW+1:2];

`ifdef WB_RESP_BURST_EN
  localparam logic [2:0] CTI_INCR = 3'b010;
  logic          burst_more;
  logic [AW-1:0] nidx;
  assign burst_more  = req & (wb_cti_i == CTI_INCR);
  assign nidx        = idx + AW'(1);
  assign bus_err     = (wb_addr_i[31:AW+2] != '0) || ((wb_cti_i == CTI_INCR) && (wb_bte_i != 2'b00));
  assign unused_bits = ^wb_addr_i[1:0];
`else
  assign bus_err     = (wb_addr_i[31:AW+2] != '0);
  assign unused_bits = ^{wb_addr_i[1:0], wb_cti_i, wb_bte_i};
`endif

  // Single RAM write port: first beat uses the latched request, burst beats use the live bus.
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [SW-1:0] mem_sel;
  logic [DW-1:0] mem_dat;

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = idx;
    mem_sel = sel_q;
    mem_dat = dat_q;
    if (state == RESP) begin
      if (!bst) mem_we = we_q & ~err_q;
`ifdef WB_RESP_BURST_EN
      else begin
        mem_we  = we_q & req & (idx != '1);
        mem_idx = nidx;
        mem_sel = wb_sel_i;
        mem_dat = wb_dat_i;
      end
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we)
      for (int b = 0; b < SW; b++)
        if (mem_sel[b]) mem[mem_idx][b*8 +: 8] <= mem_dat[b*8 +: 8];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      bst      <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      unique case (state)
        IDLE: if (req) begin
          idx   <= bus_idx;
          we_q  <= wb_we_i;
          sel_q <= wb_sel_i;
          dat_q <= wb_dat_i;
          err_q <= bus_err;
          bst   <= 1'b0;
          if (WAIT_ST == 0) begin
            state <= RESP;
            if (bus_err)       wb_dat_o <= '0;
            else if (!wb_we_i) wb_dat_o <= mem[bus_idx];
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!req) state <= IDLE;
          else if (cnt == 4'd0) begin
            state <= RESP;
            if (err_q)     wb_dat_o <= '0;
            else if (!we_q) wb_dat_o <= mem[idx];
          end else cnt <= cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          bst   <= 1'b0;
          if (!bst) begin
            wb_ack_o <= ~err_q;
            wb_err_o <= err_q;
`ifdef WB_RESP_BURST_EN
            if (!err_q && burst_more) begin
              state <= RESP;
              bst   <= 1'b1;
            end
`endif
          end
`ifdef WB_RESP_BURST_EN
          // Master presents the next beat during the previous ack cycle.
          else if (req) begin
            if (idx == '1) begin
              wb_err_o <= 1'b1;
              wb_dat_o <= '0;
            end else begin
              wb_ack_o <= 1'b1;
              idx      <= nidx;
              if (!we_q) wb_dat_o <= mem[nidx];
              if (burst_more) begin
                state <= RESP;
                bst   <= 1'b1;
              end
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_resp_mem.sv
// Self-checking bench for wb_resp_mem: scoreboard of expected responses, one task per scenario.
`timescale 1ns/1ps
module tb_wb_resp_mem;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdat = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] rdat;
  logic        ack, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [4096];

  wb_resp_mem #(.AW(AW), .DW(DW), .WAIT_ST(WS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err)
  );

  always #5 clk = ~clk;

  // Reference model: range check plus byte-lane RAM image.
  function automatic exp_t predict(input logic w, input logic [31:0] a, input logic [3:0] s,
                                   input logic [31:0] d, input logic [2:0] c, input logic [1:0] b);
    exp_t e;
    logic [11:0] i;
    i = a[13:2];
    e.is_err = (a[31:14] != 18'd0);
`ifdef WB_RESP_BURST_EN
    if (c == 3'b010 && b != 2'b00) e.is_err = 1'b1;
`else
    if (c === 3'bzzz && b === 2'bzz) e.is_err = 1'b1;
`endif
    e.dat     = 32'h0;
    e.chk_dat = e.is_err;
    if (!e.is_err) begin
      if (w) begin
        for (int k = 0; k < 4; k++) if (s[k]) mdl[i][k*8 +: 8] = d[k*8 +: 8];
      end else begin
        e.dat     = mdl[i];
        e.chk_dat = !$isunknown(mdl[i]);
      end
    end
    return e;
  endfunction

  task automatic xfer(input string name, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [2:0] c, input logic [1:0] b,
                      input logic cont, input logic hold);
    exp_t e;
    int   n;
    if (!cont) @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; sel = s; wdat = d; cti = c; bte = b;
    sb.push_back(predict(w, a, s, d, c, b));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(ack || err) && n < 40);
    if (!hold) begin cyc = 0; stb = 0; end
    e = sb.pop_front();
    checks++;
    if (n != 2 + WS) begin
      errors++; $display("FAIL %s latency: got %0d cycles, want %0d", name, n, 2 + WS);
    end
    checks++;
    if (ack !== !e.is_err || err !== e.is_err) begin
      errors++; $display("FAIL %s term: ack=%b err=%b, want ack=%b err=%b", name, ack, err, !e.is_err, e.is_err);
    end
    if (e.chk_dat) begin
      checks++;
      if (rdat !== e.dat) begin
        errors++; $display("FAIL %s data: got %h, want %h", name, rdat, e.dat);
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL %s one-cycle: ack=%b err=%b, want 0 0", name, ack, err);
      end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || rdat !== 32'h0) begin
      errors++; $display("FAIL reset: ack=%b err=%b dat=%h, want 0 0 0", ack, err, rdat);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || rdat !== 32'h0) begin
      errors++; $display("FAIL post_reset: ack=%b err=%b dat=%h, want 0 0 0", ack, err, rdat);
    end
  endtask

  task automatic test_write_read;
    xfer("wr_top",  1, 32'h0000_3FFC, 4'hF, 32'hDEADBEEF, 3'b000, 2'b00, 0, 0);
    xfer("rd_top",  0, 32'h0000_3FFC, 4'hF, 32'h0,        3'b000, 2'b00, 0, 0);
    xfer("wr_0x40000", 1, 32'h0004_0000, 4'hF, 32'h1, 3'b000, 2'b00, 0, 0);
    xfer("rd_0x4000",  0, 32'h0000_4000, 4'hF, 32'h0, 3'b000, 2'b00, 0, 0);
  endtask

  task automatic test_byte_lanes;
    xfer("bl_wr_full", 1, 32'h100, 4'hF, 32'h11223344, 3'b000, 2'b00, 0, 0);
    xfer("bl_wr_part", 1, 32'h100, 4'h5, 32'hAABBCCDD, 3'b000, 2'b00, 0, 0);
    xfer("bl_rd",      0, 32'h100, 4'h0, 32'h0,        3'b000, 2'b00, 0, 0);
    checks++;
    if (mdl[12'h040] !== 32'h11BB33DD) begin
      errors++; $display("FAIL bl_model: got %h, want 11bb33dd", mdl[12'h040]);
    end
  endtask

  task automatic test_range_err;
    xfer("re_wr0",   1, 32'h0000_0000, 4'hF, 32'hCAFEF00D, 3'b000, 2'b00, 0, 0);
    xfer("re_wrerr", 1, 32'h0040_0000, 4'hF, 32'h0BADBEEF, 3'b000, 2'b00, 0, 0);
    xfer("re_rderr", 0, 32'h0040_0000, 4'hF, 32'h0,        3'b000, 2'b00, 0, 0);
    xfer("re_rd0",   0, 32'h0000_0000, 4'hF, 32'h0,        3'b000, 2'b00, 0, 0);
  endtask

  task automatic test_abort;
    int bad;
    xfer("ab_pre", 1, 32'h180, 4'hF, 32'h12345678, 3'b000, 2'b00, 0, 0);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = 32'h180; sel = 4'hF; wdat = 32'h55; cti = 0; bte = 0;
    @(posedge clk);
    @(negedge clk); stb = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0 || err !== 1'b0) bad++;
    end
    cyc = 0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_quiet: %0d cycles with ack/err, want 0", bad);
    end
    xfer("ab_rd", 0, 32'h180, 4'hF, 32'h0, 3'b000, 2'b00, 0, 0);
  endtask

  task automatic test_back_to_back;
    xfer("b2b_w0", 1, 32'h400, 4'hF, 32'hA0A0A0A0, 3'b000, 2'b00, 0, 1);
    xfer("b2b_w1", 1, 32'h404, 4'hF, 32'hB1B1B1B1, 3'b000, 2'b00, 1, 1);
    xfer("b2b_r0", 0, 32'h400, 4'hF, 32'h0,        3'b000, 2'b00, 1, 1);
    xfer("b2b_r1", 0, 32'h404, 4'hF, 32'h0,        3'b000, 2'b00, 1, 0);
  endtask

`ifdef WB_RESP_BURST_EN
  task automatic burst(input string name, input logic w, input logic [31:0] base, input int beats);
    exp_t e;
    int   n, want;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; sel = 4'hF; bte = 0;
    for (int k = 0; k < beats; k++) begin
      addr = base + 32'(4 * k);
      wdat = 32'(k + 1);
      cti  = (k == beats - 1) ? 3'b111 : 3'b010;
      sb.push_back(predict(w, addr, sel, wdat, cti, bte));
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!(ack || err) && n < 40);
      e = sb.pop_front();
      want = (k == 0) ? 2 + WS : 1;
      checks++;
      if (n != want) begin
        errors++; $display("FAIL %s beat%0d latency: got %0d, want %0d", name, k, n, want);
      end
      checks++;
      if (ack !== !e.is_err || err !== e.is_err) begin
        errors++; $display("FAIL %s beat%0d term: ack=%b err=%b, want err=%b", name, k, ack, err, e.is_err);
      end
      if (e.chk_dat) begin
        checks++;
        if (rdat !== e.dat) begin
          errors++; $display("FAIL %s beat%0d data: got %h, want %h", name, k, rdat, e.dat);
        end
      end
    end
    cyc = 0; stb = 0; cti = 0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL %s end: ack=%b err=%b, want 0 0", name, ack, err);
    end
  endtask

  task automatic test_burst;
    burst("bw", 1, 32'h200, 4);
    burst("br", 0, 32'h200, 4);
    xfer("bst_bte_err", 0, 32'h200, 4'hF, 32'h0, 3'b010, 2'b01, 0, 0);
    burst("bx", 0, 32'h3FFC, 2);
  endtask
`else
  task automatic test_cti_ignored;
    xfer("cti_wr", 1, 32'h200, 4'hF, 32'h600DF00D, 3'b010, 2'b01, 0, 0);
    xfer("cti_rd", 0, 32'h200, 4'hF, 32'h0,        3'b010, 2'b10, 0, 0);
  endtask
`endif

  task automatic test_reset_mid;
    xfer("rm_wr", 1, 32'h300, 4'hF, 32'h0A0A0A0A, 3'b000, 2'b00, 0, 0);
    xfer("rm_rd", 0, 32'h300, 4'hF, 32'h0,        3'b000, 2'b00, 0, 0);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = 32'h300; sel = 4'hF; wdat = 32'hBBBBBBBB; cti = 0; bte = 0;
    @(posedge clk); #1;
    rst = 1; #1;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || rdat !== 32'h0) begin
      errors++; $display("FAIL reset_mid: ack=%b err=%b dat=%h, want 0 0 0", ack, err, rdat);
    end
    cyc = 0; stb = 0; we = 0;
    @(negedge clk); rst = 0;
    xfer("rm_rd_after", 0, 32'h300, 4'hF, 32'h0, 3'b000, 2'b00, 0, 0);
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_lanes;
    test_range_err;
    test_abort;
    test_back_to_back;
`ifdef WB_RESP_BURST_EN
    test_burst;
`else
    test_cti_ignored;
`endif
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
